// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
//   word_t         : 32-bit machine word.
//   fetch_state_t  : fetch FSM states (ISSUE, WAIT).
//   *_DEFAULT      : default values for the fetch stage parameters.
//   align_word()   : clears bits [1:0] to form a word-aligned address.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  localparam word_t NOP_INSTR_DEFAULT    = 32'h0000_0013;
  localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry decode output register.
//   clock, reset        : clock, synchronous active-high reset
//   load_i              : capture instr_i/pc_i as a valid instruction
//   flush_i             : discard the held instruction (highest priority)
//   consume_i           : decode takes the held instruction this cycle
//   instr_i, pc_i       : instruction word and its PC to capture
//   valid_o, instr_o, pc_o : held instruction; instr_o is NOP while empty
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  logic  consume_i,
  input  word_t instr_i,
  input  word_t pc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t pc_o
);

  logic  valid_q, valid_d;
  word_t instr_q, instr_d;
  word_t pc_q, pc_d;

  // Flush beats load beats consume. A load and a consume never collide in
  // practice (responses only land in an empty buffer), but load wins anyway.
  // dec_pc is left untouched when the buffer empties; only valid/instr clear.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one ICache request at a time,
// buffers the returned instruction for decode and handles redirects,
// squashing a request that is already in flight.
//   clock, reset                  : clock, synchronous active-high reset
//   stall                         : decode cannot accept this cycle
//   redirect_valid/target         : load new PC (target bits [1:0] ignored)
//   icache_req/addr               : one-cycle request strobe and address
//   icache_resp_valid/data        : response for the outstanding request
//   dec_valid/instr/pc            : instruction presented to decode
//   dbg_state                     : current FSM state, for observation
//
// Handshake: decode takes the instruction on any cycle where dec_valid=1 and
// stall=0; the ICache accepts every icache_req strobe and answers it with
// exactly one icache_resp_valid strobe, at the earliest one cycle later.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter word_t NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  word_t        redirect_target,
  output logic         icache_req,
  output word_t        icache_addr,
  input  logic         icache_resp_valid,
  input  word_t        icache_resp_data,
  output logic         dec_valid,
  output word_t        dec_instr,
  output word_t        dec_pc,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         squash_q, squash_d;

  logic req, buf_load, buf_flush, consume, buf_free;

  assign consume  = dec_valid & ~stall;
  // Issue only when the buffer will be empty by the time a response lands.
  assign buf_free = ~dec_valid | consume;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    req       = 1'b0;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      ISSUE: begin
        if (redirect_valid) begin
          pc_d      = align_word(redirect_target);
          buf_flush = 1'b1;
        end else if (buf_free) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d      = align_word(redirect_target);
          buf_flush = 1'b1;
          if (icache_resp_valid) begin
            // The in-flight response is here: drop it, nothing left to squash.
            squash_d = 1'b0;
            state_d  = ISSUE;
          end else begin
            // Remember to drop the response that is still coming.
            squash_d = 1'b1;
          end
        end else if (icache_resp_valid) begin
          state_d  = ISSUE;
          squash_d = 1'b0;
          if (!squash_q) begin
            buf_load = 1'b1;
            pc_d     = pc_q + 32'd4;
          end
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ISSUE;
      pc_q     <= RESET_VECTOR;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
    end
  end

  // No strobe while reset is held, whatever state the FSM was in.
  assign icache_req  = req & ~reset;
  assign icache_addr = pc_q;
  assign dbg_state   = state_q;

  fetch_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .load_i    (buf_load),
    .flush_i   (buf_flush),
    .consume_i (consume),
    .instr_i   (icache_resp_data),
    .pc_i      (pc_q),
    .valid_o   (dec_valid),
    .instr_o   (dec_instr),
    .pc_o      (dec_pc)
  );

endmodule
